axil_req_scheduler: RTL and testbench

//  Shares one AXI4-Lite master port between N_REQ on-chip requesters, e.g. the

---
 rtl/axil_req_scheduler.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_axil_req_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : axil_req_scheduler
// Description : Shares a single AXI4-Lite master port between N_REQ on-chip
//               requesters. One single-beat read or write is in flight at a
//               time; requesters are granted in round-robin order.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   ACLK, ARESETN            clock, asynchronous active-low reset
//   req_valid[N_REQ]         requester i has a pending transaction
//   req_wr[N_REQ]            1 = write, 0 = read
//   req_addr[N_REQ*ADDR_W]   flattened addresses, slice i = requester i
//   req_wdata[N_REQ*DATA_W]  flattened write data
//   req_ready[N_REQ]         one-hot accept pulse (grant cycle)
//   rsp_valid[N_REQ]         one-hot completion pulse
//   rsp_rdata[DATA_W]        read data, valid with rsp_valid
//   rsp_err                  SLVERR/DECERR/timeout, valid with rsp_valid
//   busy                     transaction in flight (any state but IDLE)
//   M_AXI_*                  AXI4-Lite master channels (PROT=0, WSTRB=all 1s)
// Build option
//   AXIL_SCHED_TIMEOUT_EN    enables a TIMEOUT_CYC-cycle watchdog per state
// ============================================================================
module axil_req_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_wr,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         M_AXI_AWADDR,
    output logic [2:0]                M_AXI_AWPROT,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_W-1:0]         M_AXI_WDATA,
    output logic [DATA_W/8-1:0]       M_AXI_WSTRB,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY,
    output logic [ADDR_W-1:0]         M_AXI_ARADDR,
    output logic [2:0]                M_AXI_ARPROT,
    output logic                      M_AXI_ARVALID,
    input  logic                      M_AXI_ARREADY,
    input  logic [DATA_W-1:0]         M_AXI_RDATA,
    input  logic [1:0]                M_AXI_RRESP,
    input  logic                      M_AXI_RVALID,
    output logic                      M_AXI_RREADY
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_CNT_W = c_IDX_W + 1;
    localparam logic [c_CNT_W-1:0] c_N    = c_CNT_W'(N_REQ);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AXW   = 3'd1,
        S_WRESP = 3'd2,
        S_AXR   = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t r_state;
    state_t w_state_base;
    state_t w_state_nxt;

    logic [c_IDX_W-1:0] r_rr_ptr;
    logic [c_IDX_W-1:0] r_grant_idx;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;
    logic               r_awvalid;
    logic               r_wvalid;
    logic               r_bready;
    logic               r_arvalid;
    logic               r_rready;

    logic               w_any;
    logic [c_IDX_W-1:0] w_grant_idx;
    logic [N_REQ-1:0]   w_grant_oh;
    logic [N_REQ-1:0]   w_done_oh;
    logic               w_sel_wr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_aw_done;
    logic               w_w_done;
    logic               w_wait_state;
    logic               w_expired;
    logic               w_to_fire;

    // ------------------------------------------------------------------
    // Round-robin search: first requesting index at or after r_rr_ptr.
    // r_rr_ptr < N_REQ, so one conditional subtraction wraps the sum.
    // ------------------------------------------------------------------
    always_comb begin
        logic [c_CNT_W-1:0] w_sum;
        w_any       = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + c_CNT_W'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            if (!w_any && req_valid[w_sum[c_IDX_W-1:0]]) begin
                w_any       = 1'b1;
                w_grant_idx = w_sum[c_IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_grant_oh  = '0;
        w_done_oh   = '0;
        w_sel_wr    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_grant_oh[j] = w_any && (w_grant_idx == c_IDX_W'(j));
            w_done_oh[j]  = (r_state == S_DONE) && (r_grant_idx == c_IDX_W'(j));
            if (w_grant_idx == c_IDX_W'(j)) begin
                w_sel_wr    = req_wr[j];
                w_sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // A write channel counts as finished if it already handshook earlier
    // (its VALID dropped) or handshakes this cycle.
    assign w_aw_done    = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done     = !r_wvalid  || M_AXI_WREADY;
    assign w_wait_state = (r_state == S_AXW)  || (r_state == S_WRESP) ||
                          (r_state == S_AXR)  || (r_state == S_RDATA);

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef AXIL_SCHED_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    // Cleared on every state entry, counts while waiting on the slave.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_to_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_to_cnt <= '0;
        end else if (w_wait_state) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_expired = (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));
`else
    // Without the watchdog the limit is inert; the trigger is constant false.
    localparam logic c_TO_NEVER = (TIMEOUT_CYC < 0);
    assign w_expired = c_TO_NEVER;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A completing handshake takes precedence over an
    // expiring watchdog in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_base = r_state;
        w_state_nxt  = r_state;
        w_to_fire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_base = w_sel_wr ? S_AXW : S_AXR;
                end
            end
            S_AXW: begin
                if (w_aw_done && w_w_done) begin
                    w_state_base = S_WRESP;
                end
            end
            S_WRESP: begin
                if (M_AXI_BVALID) begin
                    w_state_base = S_DONE;
                end
            end
            S_AXR: begin
                if (M_AXI_ARREADY) begin
                    w_state_base = S_RDATA;
                end
            end
            S_RDATA: begin
                if (M_AXI_RVALID) begin
                    w_state_base = S_DONE;
                end
            end
            S_DONE: begin
                w_state_base = S_IDLE;
            end
            default: begin
                w_state_base = S_IDLE;
            end
        endcase
        w_state_nxt = w_state_base;
        if (w_wait_state && w_expired && (w_state_base == r_state)) begin
            w_to_fire   = 1'b1;
            w_state_nxt = S_DONE;
        end
    end

    // ------------------------------------------------------------------
    // Registered master handshakes, payload and response capture
    // ------------------------------------------------------------------
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            // AW and W each hold until their own handshake while in AXW.
            r_awvalid <= (w_state_nxt == S_AXW) &&
                         ((r_state == S_IDLE) || (r_awvalid && !M_AXI_AWREADY));
            r_wvalid  <= (w_state_nxt == S_AXW) &&
                         ((r_state == S_IDLE) || (r_wvalid && !M_AXI_WREADY));
            r_bready  <= (w_state_nxt == S_WRESP);
            r_arvalid <= (w_state_nxt == S_AXR);
            r_rready  <= (w_state_nxt == S_RDATA);

            if ((r_state == S_IDLE) && w_any) begin
                r_grant_idx <= w_grant_idx;
                r_addr      <= w_sel_addr;
                r_wdata     <= w_sel_wdata;
            end

            if ((r_state == S_WRESP) && M_AXI_BVALID) begin
                r_err   <= (M_AXI_BRESP != 2'b00);
                r_rdata <= '0;
            end else if ((r_state == S_RDATA) && M_AXI_RVALID) begin
                r_err   <= (M_AXI_RRESP != 2'b00);
                r_rdata <= M_AXI_RDATA;
            end else if (w_to_fire) begin
                r_err   <= 1'b1;
                r_rdata <= '0;
            end

            if (r_state == S_DONE) begin
                r_rr_ptr <= (r_grant_idx == c_LAST) ? '0 : r_grant_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready     = (r_state == S_IDLE) ? w_grant_oh : '0;
    assign rsp_valid     = w_done_oh;
    assign rsp_rdata     = r_rdata;
    assign rsp_err       = r_err && (r_state == S_DONE);
    assign busy          = (r_state != S_IDLE);

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_axil_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_req_scheduler
// Description : Directed self-checking bench for axil_req_scheduler (N_REQ=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_req_scheduler;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            ACLK;
    logic            ARESETN;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_wr;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            busy;
    logic [AW-1:0]   M_AXI_AWADDR;
    logic [2:0]      M_AXI_AWPROT;
    logic            M_AXI_AWVALID;
    logic            M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WVALID;
    logic            M_AXI_WREADY;
    logic [1:0]      M_AXI_BRESP;
    logic            M_AXI_BVALID;
    logic            M_AXI_BREADY;
    logic [AW-1:0]   M_AXI_ARADDR;
    logic [2:0]      M_AXI_ARPROT;
    logic            M_AXI_ARVALID;
    logic            M_AXI_ARREADY;
    logic [DW-1:0]   M_AXI_RDATA;
    logic [1:0]      M_AXI_RRESP;
    logic            M_AXI_RVALID;
    logic            M_AXI_RREADY;

    int n_vec;
    int n_err;
    int aw_hs;
    int w_hs;

    axil_req_scheduler #(
        .N_REQ       (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (1024)
    ) dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .req_valid     (req_valid),
        .req_wr        (req_wr),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWPROT  (M_AXI_AWPROT),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARPROT  (M_AXI_ARPROT),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // Handshake monitor on the active edge.
    initial begin
        aw_hs = 0;
        w_hs  = 0;
    end
    always @(posedge ACLK) begin
        if (ARESETN) begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs = aw_hs + 1;
            if (M_AXI_WVALID  && M_AXI_WREADY)  w_hs  = w_hs + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec = n_vec + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int aw0;
        int w0;
        int ngrant;
        logic found;
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n_vec = 0;
        n_err = 0;
        ARESETN = 1'b0;
        req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge ACLK);
        #1;
        chk("rst_busy",    busy, 0);
        chk("rst_awvalid", M_AXI_AWVALID, 0);
        chk("rst_wvalid",  M_AXI_WVALID, 0);
        chk("rst_arvalid", M_AXI_ARVALID, 0);
        chk("rst_bready",  M_AXI_BREADY, 0);
        chk("rst_rready",  M_AXI_RREADY, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rdata",   rsp_rdata, 0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // ---------------- 1: single write, req 0 ----------------
        @(negedge ACLK);
        req_valid = 4'b0001; req_wr = 4'b0001;
        req_addr[0 +: 32] = 32'h10; req_wdata[0 +: 32] = 32'hA5A5_0001;
        #1;
        chk("t1_req_ready", req_ready, 4'b0001);
        chk("t1_busy_grant", busy, 0);
        chk("t1_awvalid_grant", M_AXI_AWVALID, 0);
        @(negedge ACLK);
        req_valid = '0;
        #1;
        chk("t1_req_ready_off", req_ready, 0);
        chk("t1_awvalid", M_AXI_AWVALID, 1);
        chk("t1_wvalid",  M_AXI_WVALID, 1);
        chk("t1_awaddr",  M_AXI_AWADDR, 32'h10);
        chk("t1_wdata",   M_AXI_WDATA, 32'hA5A5_0001);
        chk("t1_wstrb",   M_AXI_WSTRB, 4'hF);
        chk("t1_awprot",  M_AXI_AWPROT, 0);
        chk("t1_busy",    busy, 1);
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        @(negedge ACLK);
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        #1;
        chk("t1_awvalid_drop", M_AXI_AWVALID, 0);
        chk("t1_wvalid_drop",  M_AXI_WVALID, 0);
        chk("t1_bready", M_AXI_BREADY, 1);
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b00;
        @(negedge ACLK);
        M_AXI_BVALID = 0;
        #1;
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_err",   rsp_err, 0);
        chk("t1_bready_off", M_AXI_BREADY, 0);
        chk("t1_aw_hs", aw_hs, 1);
        chk("t1_w_hs",  w_hs, 1);
        @(negedge ACLK);
        #1;
        chk("t1_idle_busy", busy, 0);
        chk("t1_rsp_valid_off", rsp_valid, 0);

        // ---------------- 2: read, req 2 ----------------
        @(negedge ACLK);
        req_valid = 4'b0100; req_wr = 4'b0000; req_addr[64 +: 32] = 32'h20;
        #1;
        chk("t2_req_ready", req_ready, 4'b0100);
        @(negedge ACLK);
        req_valid = '0;
        #1;
        chk("t2_arvalid", M_AXI_ARVALID, 1);
        chk("t2_araddr",  M_AXI_ARADDR, 32'h20);
        chk("t2_arprot",  M_AXI_ARPROT, 0);
        chk("t2_no_aw",   M_AXI_AWVALID, 0);
        M_AXI_ARREADY = 1;
        @(negedge ACLK);
        M_AXI_ARREADY = 0;
        #1;
        chk("t2_arvalid_drop", M_AXI_ARVALID, 0);
        chk("t2_rready", M_AXI_RREADY, 1);
        M_AXI_RVALID = 1; M_AXI_RDATA = 32'hDEAD_BEEF; M_AXI_RRESP = 2'b00;
        @(negedge ACLK);
        M_AXI_RVALID = 0; M_AXI_RDATA = 0;
        #1;
        chk("t2_rsp_valid", rsp_valid, 4'b0100);
        chk("t2_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t2_rsp_err", rsp_err, 0);
        @(negedge ACLK);

        // ---------------- 6: reset while in WRESP (req 1) ----------------
        req_valid = 4'b0010; req_wr = 4'b0010; req_addr[32 +: 32] = 32'h44;
        #1;
        chk("t6_req_ready", req_ready, 4'b0010);
        @(negedge ACLK);
        req_valid = '0; M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        @(negedge ACLK);
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        #1;
        chk("t6_bready", M_AXI_BREADY, 1);
        @(negedge ACLK);
        ARESETN = 1'b0;
        M_AXI_BVALID = 1;
        #1;
        chk("t6_rst_bready", M_AXI_BREADY, 0);
        chk("t6_rst_busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge ACLK);
            #1;
            chk("t6_rst_no_rsp", rsp_valid, 0);
        end
        @(negedge ACLK);
        M_AXI_BVALID = 0;
        ARESETN = 1'b1;
        #1;
        chk("t6_rel_no_rsp", rsp_valid, 0);

        // ---------------- 3: round-robin, all requesters held ----------------
        // First grant after reset must go to req 0.
        @(negedge ACLK);
        req_valid = 4'b1111; req_wr = 4'b1111;
        M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_ARREADY = 1;
        M_AXI_BVALID = 1; M_AXI_BRESP = 0; M_AXI_RVALID = 1;
        ngrant = 0;
        for (int c = 0; c < 60 && ngrant < 5; c++) begin
            #1;
            if (req_ready != 0) begin
                chk("t3_grant", req_ready, rr_exp[ngrant]);
                ngrant = ngrant + 1;
            end
            @(negedge ACLK);
        end
        chk("t3_grant_count", ngrant, 5);
        req_valid = '0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!busy) break;
            @(negedge ACLK);
        end
        chk("t3_idle", busy, 0);
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0;
        M_AXI_BVALID = 0; M_AXI_RVALID = 0;

        // ---------------- 4a: AWREADY 3 cycles before WREADY (req 1) ----------------
        @(negedge ACLK);
        aw0 = aw_hs; w0 = w_hs;
        req_valid = 4'b0010; req_wr = 4'b0010;
        req_addr[32 +: 32] = 32'h100; req_wdata[32 +: 32] = 32'h1111_2222;
        #1;
        chk("t4a_req_ready", req_ready, 4'b0010);
        @(negedge ACLK);
        req_valid = '0; M_AXI_AWREADY = 1;
        @(negedge ACLK);
        M_AXI_AWREADY = 0;
        #1;
        chk("t4a_aw_drop", M_AXI_AWVALID, 0);
        chk("t4a_w_hold",  M_AXI_WVALID, 1);
        chk("t4a_no_bready", M_AXI_BREADY, 0);
        @(negedge ACLK);
        #1;
        chk("t4a_aw_stays_low", M_AXI_AWVALID, 0);
        @(negedge ACLK);
        M_AXI_WREADY = 1;
        #1;
        chk("t4a_wdata", M_AXI_WDATA, 32'h1111_2222);
        @(negedge ACLK);
        M_AXI_WREADY = 0;
        #1;
        chk("t4a_w_drop", M_AXI_WVALID, 0);
        chk("t4a_bready", M_AXI_BREADY, 1);
        chk("t4a_aw_hs", aw_hs - aw0, 1);
        chk("t4a_w_hs",  w_hs - w0, 1);
        M_AXI_BVALID = 1;
        @(negedge ACLK);
        M_AXI_BVALID = 0;
        #1;
        chk("t4a_rsp_valid", rsp_valid, 4'b0010);

        // ---------------- 4b: WREADY 3 cycles before AWREADY (req 2) ----------------
        @(negedge ACLK);
        aw0 = aw_hs; w0 = w_hs;
        req_valid = 4'b0100; req_wr = 4'b0100;
        req_addr[64 +: 32] = 32'h30; req_wdata[64 +: 32] = 32'h3333_4444;
        #1;
        chk("t4b_req_ready", req_ready, 4'b0100);
        @(negedge ACLK);
        req_valid = '0; M_AXI_WREADY = 1;
        @(negedge ACLK);
        M_AXI_WREADY = 0;
        #1;
        chk("t4b_w_drop",  M_AXI_WVALID, 0);
        chk("t4b_aw_hold", M_AXI_AWVALID, 1);
        @(negedge ACLK);
        #1;
        chk("t4b_aw_hold2", M_AXI_AWVALID, 1);
        @(negedge ACLK);
        M_AXI_AWREADY = 1;
        #1;
        chk("t4b_awaddr", M_AXI_AWADDR, 32'h30);
        @(negedge ACLK);
        M_AXI_AWREADY = 0;
        #1;
        chk("t4b_aw_drop", M_AXI_AWVALID, 0);
        chk("t4b_bready", M_AXI_BREADY, 1);
        chk("t4b_aw_hs", aw_hs - aw0, 1);
        chk("t4b_w_hs",  w_hs - w0, 1);
        M_AXI_BVALID = 1;
        @(negedge ACLK);
        M_AXI_BVALID = 0;
        #1;
        chk("t4b_rsp_valid", rsp_valid, 4'b0100);

        // ---------------- 5: SLVERR on write (req 3) ----------------
        @(negedge ACLK);
        req_valid = 4'b1000; req_wr = 4'b1000;
        #1;
        chk("t5_req_ready", req_ready, 4'b1000);
        @(negedge ACLK);
        req_valid = '0; M_AXI_AWREADY = 1; M_AXI_WREADY = 1;
        @(negedge ACLK);
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0;
        M_AXI_BVALID = 1; M_AXI_BRESP = 2'b10;
        @(negedge ACLK);
        M_AXI_BVALID = 0; M_AXI_BRESP = 2'b00;
        #1;
        chk("t5_rsp_valid", rsp_valid, 4'b1000);
        chk("t5_rsp_err", rsp_err, 1);
        @(negedge ACLK);
        #1;
        chk("t5_err_clear", rsp_err, 0);
        chk("t5_idle", busy, 0);

`ifdef AXIL_SCHED_TIMEOUT_EN
        // ---------------- 5b: read timeout (req 0) ----------------
        @(negedge ACLK);
        req_valid = 4'b0001; req_wr = 4'b0000;
        #1;
        chk("t5b_req_ready", req_ready, 4'b0001);
        @(negedge ACLK);
        req_valid = '0; M_AXI_ARREADY = 1;
        @(negedge ACLK);
        M_AXI_ARREADY = 0;
        #1;
        chk("t5b_rready", M_AXI_RREADY, 1);
        found = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge ACLK);
            #1;
            if (rsp_valid != 0) begin
                found = 1'b1;
                break;
            end
        end
        chk("t5b_seen", found, 1);
        chk("t5b_rsp_valid", rsp_valid, 4'b0001);
        chk("t5b_rsp_err", rsp_err, 1);
        chk("t5b_rdata", rsp_rdata, 0);
        chk("t5b_rready_off", M_AXI_RREADY, 0);
        @(negedge ACLK);
        #1;
        chk("t5b_idle", busy, 0);
`else
        found = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
